// File: rtl/ad_scan_sched.sv
// ---------------------------------------------------------------------------
// ad_scan_sched
//
// Conversion scheduler for up to eight AD channel front-ends. A period
// counter driven by the microsecond strobe raises a tick. Each tick (or a
// pending single-shot request) starts one scan. A scan pulses ad_start for
// each enabled channel in ascending order, with GAP clk_sys cycles between
// starts. It then waits until every enabled channel has dropped its busy
// flag, and ends with a one-cycle scan_done pulse.
//
// Configuration and status are reached through the fx bus slave at dev_id.
//   0x00 CTRL     [0] RUN, [1] SHOT (self-clearing), [2] CLR (write-only)
//   0x01 CH_EN    channel enable mask (bits >= NCH read 0)
//   0x02/0x03     PERIOD lo/hi in us (0 behaves as 1)
//   0x04 GAP      clk_sys cycles between starts
//   0x05 STATUS   [0] BUSY, [1] OVR, [4:2] channel index, [5] TMO
//   0x06/0x07     SCAN_CNT lo/hi
//
// Optional build macro SCAN_TIMEOUT_EN: when defined, WAIT_DONE gives up
// after 255 microsecond ticks and sets TMO. No scan_done is pulsed and
// SCAN_CNT is left unchanged. When undefined, STATUS[5] reads 0.
//
// Ports
//   clk_sys, rst_n     system clock, asynchronous active-low reset
//   pluse_us           one-cycle strobe every microsecond
//   dev_id             fx bus device id of this slave
//   fx_waddr/wr/data   fx write port
//   fx_rd/raddr, fx_q  fx read port; fx_q is registered, 0 when unselected
//   ad_busy[NCH]       per-channel conversion in progress
//   ad_start[NCH]      per-channel one-cycle start pulse
//   scan_done          one-cycle pulse at the end of each completed scan
// ---------------------------------------------------------------------------
module ad_scan_sched #(
    parameter int          NCH        = 8,
    parameter logic [15:0] PERIOD_RST = 16'd1000,
    parameter logic [7:0]  GAP_RST    = 8'd4
) (
    input  logic           clk_sys,
    input  logic           rst_n,
    input  logic           pluse_us,
    input  logic [5:0]     dev_id,
    input  logic [21:0]    fx_waddr,
    input  logic           fx_wr,
    input  logic [7:0]     fx_data,
    input  logic           fx_rd,
    input  logic [21:0]    fx_raddr,
    output logic [7:0]     fx_q,
    input  logic [NCH-1:0] ad_busy,
    output logic [NCH-1:0] ad_start,
    output logic           scan_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_GAP,
        S_WAIT
    } state_t;

    localparam logic [7:0] A_CTRL    = 8'h00;
    localparam logic [7:0] A_CH_EN   = 8'h01;
    localparam logic [7:0] A_PER_LO  = 8'h02;
    localparam logic [7:0] A_PER_HI  = 8'h03;
    localparam logic [7:0] A_GAP     = 8'h04;
    localparam logic [7:0] A_STATUS  = 8'h05;
    localparam logic [7:0] A_CNT_LO  = 8'h06;
    localparam logic [7:0] A_CNT_HI  = 8'h07;

    // Returns {found, index} of the lowest enabled channel at or above 'from'.
    function automatic logic [3:0] find_ch(input logic [NCH-1:0] en,
                                           input logic [3:0]     from);
        logic [3:0] res;
        res = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (en[i] && (i >= int'(from))) begin
                res = {1'b1, 3'(i)};
            end
        end
        return res;
    endfunction

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    logic           r_run;
    logic           r_shot;
    logic [NCH-1:0] r_ch_en;
    logic [15:0]    r_period;
    logic [7:0]     r_gap;
    logic           r_ovr;
    logic           r_tmo;
    logic [15:0]    r_scan_cnt;
    logic [15:0]    r_per_cnt;
    logic [7:0]     r_fx_q;
    logic           r_scan_done;

    state_t         r_state;
    logic [2:0]     r_ch;
    logic [7:0]     r_gap_cnt;
    logic           r_guard;
    logic [NCH-1:0] r_en_snap;
    logic [7:0]     r_gap_snap;

    // -----------------------------------------------------------------------
    // Bus decode
    // -----------------------------------------------------------------------
    logic       w_wsel;
    logic       w_rsel;
    logic [7:0] w_woff;
    logic [7:0] w_roff;
    logic       w_clr;
    logic       w_shot_set;

    assign w_wsel     = fx_wr && (fx_waddr[21:16] == dev_id);
    assign w_rsel     = fx_rd && (fx_raddr[21:16] == dev_id);
    assign w_woff     = fx_waddr[7:0];
    assign w_roff     = fx_raddr[7:0];
    assign w_clr      = w_wsel && (w_woff == A_CTRL) && fx_data[2];
    assign w_shot_set = w_wsel && (w_woff == A_CTRL) && fx_data[1];

    // Address bits between the offset and the device id are not decoded.
    logic w_unused_addr;
    assign w_unused_addr = ^{fx_waddr[15:8], fx_raddr[15:8]};

    // -----------------------------------------------------------------------
    // Period counter and tick
    // -----------------------------------------------------------------------
    logic [15:0] w_period_eff;
    logic        w_tick;

    assign w_period_eff = (r_period == 16'd0) ? 16'd1 : r_period;
    // '>=' rather than '==' so a PERIOD lowered below the running count
    // still produces a tick on the next microsecond instead of wrapping.
    assign w_tick = r_run && pluse_us && (r_per_cnt >= (w_period_eff - 16'd1));

    // NOTE: sequential state is always assigned with non-blocking '<=' so every
    // flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_per_cnt <= '0;
        end else if (!r_run) begin
            r_per_cnt <= '0;
        end else if (w_tick) begin
            r_per_cnt <= '0;
        end else if (pluse_us) begin
            r_per_cnt <= r_per_cnt + 16'd1;
        end
    end

    // -----------------------------------------------------------------------
    // Optional WAIT_DONE timeout
    // -----------------------------------------------------------------------
    logic w_to_expire;

`ifdef SCAN_TIMEOUT_EN
    logic [7:0] r_to_cnt;

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
        end else if (r_state != S_WAIT) begin
            r_to_cnt <= '0;
        end else if (pluse_us) begin
            r_to_cnt <= r_to_cnt + 8'd1;
        end
    end

    // The 255th microsecond tick spent in WAIT_DONE ends the wait.
    assign w_to_expire = (r_state == S_WAIT) && pluse_us && (r_to_cnt == 8'd254);
`else
    assign w_to_expire = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Scan FSM: next-state logic
    // -----------------------------------------------------------------------
    state_t     w_state_nxt;
    logic [2:0] w_ch_nxt;
    logic [7:0] w_gap_cnt_nxt;
    logic       w_scan_begin;
    logic       w_scan_end;
    logic       w_tmo_set;
    logic [3:0] w_first;
    logic [3:0] w_next;

    assign w_first = find_ch(r_ch_en, 4'd0);
    assign w_next  = find_ch(r_en_snap, {1'b0, r_ch} + 4'd1);

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_ch_nxt      = r_ch;
        w_gap_cnt_nxt = r_gap_cnt;
        w_scan_begin  = 1'b0;
        w_scan_end    = 1'b0;
        w_tmo_set     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_tick || r_shot) begin
                    w_scan_begin = 1'b1;
                    if (w_first[3]) begin
                        w_state_nxt = S_START;
                        w_ch_nxt    = w_first[2:0];
                    end else begin
                        // Empty enable mask: the scan completes immediately.
                        w_scan_end = 1'b1;
                    end
                end
            end

            S_START: begin
                if (r_gap_snap != 8'd0) begin
                    w_state_nxt   = S_GAP;
                    w_gap_cnt_nxt = r_gap_snap - 8'd1;
                end else if (w_next[3]) begin
                    w_ch_nxt = w_next[2:0];
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end

            S_GAP: begin
                if (r_gap_cnt != 8'd0) begin
                    w_gap_cnt_nxt = r_gap_cnt - 8'd1;
                end else if (w_next[3]) begin
                    w_state_nxt = S_START;
                    w_ch_nxt    = w_next[2:0];
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end

            S_WAIT: begin
                // The guard cycle gives the last started channel one clock
                // to raise its busy flag before it is sampled.
                if (!r_guard) begin
                    if ((ad_busy & r_en_snap) == '0) begin
                        w_scan_end  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else if (w_to_expire) begin
                        w_tmo_set   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Scan FSM: state register and per-scan snapshots
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_ch       <= '0;
            r_gap_cnt  <= '0;
            r_guard    <= 1'b0;
            r_en_snap  <= '0;
            r_gap_snap <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_ch      <= w_ch_nxt;
            r_gap_cnt <= w_gap_cnt_nxt;
            r_guard   <= (w_state_nxt == S_WAIT) && (r_state != S_WAIT);
            if (w_scan_begin) begin
                r_en_snap  <= r_ch_en;
                r_gap_snap <= r_gap;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Control/status registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_run       <= 1'b0;
            r_shot      <= 1'b0;
            r_ch_en     <= '1;
            r_period    <= PERIOD_RST;
            r_gap       <= GAP_RST;
            r_ovr       <= 1'b0;
            r_tmo       <= 1'b0;
            r_scan_cnt  <= '0;
            r_scan_done <= 1'b0;
        end else begin
            if (w_wsel) begin
                case (w_woff)
                    A_CTRL:   r_run          <= fx_data[0];
                    A_CH_EN:  r_ch_en        <= fx_data[NCH-1:0];
                    A_PER_LO: r_period[7:0]  <= fx_data;
                    A_PER_HI: r_period[15:8] <= fx_data;
                    A_GAP:    r_gap          <= fx_data;
                    default:  ;
                endcase
            end

            // A fresh write wins over the consumption of an older request.
            if (w_shot_set) begin
                r_shot <= 1'b1;
            end else if (w_scan_begin) begin
                r_shot <= 1'b0;
            end

            // Set has priority over clear so a coincident overrun is kept.
            if (w_tick && (r_state != S_IDLE)) begin
                r_ovr <= 1'b1;
            end else if (w_clr) begin
                r_ovr <= 1'b0;
            end

            if (w_tmo_set) begin
                r_tmo <= 1'b1;
            end else if (w_clr) begin
                r_tmo <= 1'b0;
            end

            r_scan_done <= w_scan_end;
            if (w_scan_end) begin
                r_scan_cnt <= r_scan_cnt + 16'd1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Read data
    // -----------------------------------------------------------------------
    logic [7:0] w_rd_data;

    always_comb begin
        w_rd_data = 8'h00;
        case (w_roff)
            A_CTRL:   w_rd_data = {6'd0, r_shot, r_run};
            A_CH_EN:  w_rd_data = 8'(r_ch_en);
            A_PER_LO: w_rd_data = r_period[7:0];
            A_PER_HI: w_rd_data = r_period[15:8];
            A_GAP:    w_rd_data = r_gap;
            A_STATUS: w_rd_data = {2'b00, r_tmo, r_ch, r_ovr, (r_state != S_IDLE)};
            A_CNT_LO: w_rd_data = r_scan_cnt[7:0];
            A_CNT_HI: w_rd_data = r_scan_cnt[15:8];
            default:  w_rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_fx_q <= 8'h00;
        end else begin
            r_fx_q <= w_rsel ? w_rd_data : 8'h00;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    logic [NCH-1:0] w_start;

    always_comb begin
        w_start = '0;
        if (r_state == S_START) begin
            w_start[r_ch] = 1'b1;
        end
    end

    assign ad_start  = w_start;
    assign scan_done = r_scan_done;
    assign fx_q      = r_fx_q;

endmodule

// File: tb/tb_ad_scan_sched.sv
// ---------------------------------------------------------------------------
// Self-checking bench for ad_scan_sched. Expected bus read data and expected
// start pulses go into queues when the stimulus is issued. Monitors pop and
// compare them when the DUT produces fx_q or ad_start.
// ---------------------------------------------------------------------------
module tb_ad_scan_sched;

    localparam int US = 10;  // clk_sys cycles per microsecond

    typedef struct {
        logic [7:0] mask;
        int         gap;     // expected cycles since previous start, <=0 skips
    } start_exp_t;

    typedef struct {
        string      tag;
        logic [7:0] exp;
    } rd_exp_t;

    logic        clk_sys;
    logic        rst_n;
    logic        pluse_us;
    logic [5:0]  dev_id;
    logic [21:0] fx_waddr;
    logic        fx_wr;
    logic [7:0]  fx_data;
    logic        fx_rd;
    logic [21:0] fx_raddr;
    logic [7:0]  fx_q;
    logic [7:0]  ad_busy;
    logic [7:0]  ad_start;
    logic        scan_done;

    start_exp_t st_q[$];
    rd_exp_t    rd_q[$];

    int  n_checks = 0;
    int  n_errors = 0;
    int  n_done   = 0;
    int  cyc      = 0;
    int  last_start = -1000;
    int  last_done  = -1;
    int  done_gap_exp = 0;
    logic rd_d = 1'b0;

    ad_scan_sched dut (
        .clk_sys   (clk_sys),
        .rst_n     (rst_n),
        .pluse_us  (pluse_us),
        .dev_id    (dev_id),
        .fx_waddr  (fx_waddr),
        .fx_wr     (fx_wr),
        .fx_data   (fx_data),
        .fx_rd     (fx_rd),
        .fx_raddr  (fx_raddr),
        .fx_q      (fx_q),
        .ad_busy   (ad_busy),
        .ad_start  (ad_start),
        .scan_done (scan_done)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    initial begin
        int c;
        c = 0;
        pluse_us = 1'b0;
        forever begin
            @(posedge clk_sys);
            #1;
            pluse_us = (c == US - 1);
            c = (c == US - 1) ? 0 : c + 1;
        end
    end

    always @(posedge clk_sys) begin
        cyc  <= cyc + 1;
        rd_d <= fx_rd;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Read data monitor.
    always @(negedge clk_sys) begin
        if (rd_d) begin
            if (rd_q.size() == 0) begin
                check("rd_unexpected", 32'(fx_q), 32'h0);
            end else begin
                rd_exp_t e;
                e = rd_q.pop_front();
                check(e.tag, 32'(fx_q), 32'(e.exp));
            end
        end
    end

    // Start pulse monitor.
    always @(negedge clk_sys) begin
        if (ad_start !== 8'h00) begin
            if (st_q.size() == 0) begin
                check("start_unexpected", 32'(ad_start), 32'h0);
            end else begin
                start_exp_t e;
                e = st_q.pop_front();
                check("start_mask", 32'(ad_start), 32'(e.mask));
                if (e.gap > 0) begin
                    check("start_spacing", 32'(cyc - last_start), 32'(e.gap));
                end
            end
            last_start = cyc;
        end
    end

    // scan_done monitor.
    always @(negedge clk_sys) begin
        if (scan_done) begin
            n_done++;
            if (done_gap_exp > 0 && last_done >= 0) begin
                check("done_period", 32'(cyc - last_done), 32'(done_gap_exp));
            end
            last_done = cyc;
        end
    end

    task automatic wr(input logic [7:0] off, input logic [7:0] data);
        @(posedge clk_sys);
        #1;
        fx_wr    = 1'b1;
        fx_waddr = {dev_id, 8'h00, off};
        fx_data  = data;
        @(posedge clk_sys);
        #1;
        fx_wr = 1'b0;
    endtask

    task automatic rd_dev(input string tag, input logic [5:0] dev,
                          input logic [7:0] off, input logic [7:0] exp);
        rd_exp_t e;
        @(posedge clk_sys);
        #1;
        e.tag = tag;
        e.exp = exp;
        rd_q.push_back(e);
        fx_rd    = 1'b1;
        fx_raddr = {dev, 8'h00, off};
        @(posedge clk_sys);
        #1;
        fx_rd = 1'b0;
        @(posedge clk_sys);
        #1;
    endtask

    task automatic rd(input string tag, input logic [7:0] off, input logic [7:0] exp);
        rd_dev(tag, dev_id, off, exp);
    endtask

    task automatic push_start(input logic [7:0] mask, input int gap);
        start_exp_t e;
        e.mask = mask;
        e.gap  = gap;
        st_q.push_back(e);
    endtask

    task automatic wait_done(input int n, input int budget);
        int k;
        k = 0;
        while (n_done < n && k < budget) begin
            @(posedge clk_sys);
            k++;
        end
        @(posedge clk_sys);
        #1;
        check("done_count", 32'(n_done), 32'(n));
    endtask

    task automatic wait_starts(input int budget);
        int k;
        k = 0;
        while (st_q.size() > 0 && k < budget) begin
            @(posedge clk_sys);
            k++;
        end
        #1;
        check("starts_left", 32'(st_q.size()), 32'h0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        dev_id   = 6'h02;
        fx_waddr = '0;
        fx_wr    = 1'b0;
        fx_data  = '0;
        fx_rd    = 1'b0;
        fx_raddr = '0;
        ad_busy  = '0;

        // Reset state.
        idle(3);
        check("rst_ad_start", 32'(ad_start), 32'h0);
        check("rst_scan_done", 32'(scan_done), 32'h0);
        check("rst_fx_q", 32'(fx_q), 32'h0);
        rst_n = 1'b1;
        rd("rst_ctrl", 8'h00, 8'h00);
        rd("rst_ch_en", 8'h01, 8'hFF);
        rd("rst_per_lo", 8'h02, 8'hE8);
        rd("rst_per_hi", 8'h03, 8'h03);
        rd("rst_gap", 8'h04, 8'h04);
        rd("rst_status", 8'h05, 8'h00);
        rd("rst_cnt_lo", 8'h06, 8'h00);
        rd_dev("rd_other_dev", 6'h03, 8'h01, 8'h00);
        rd("rd_unmapped", 8'h10, 8'h00);

        // Basic periodic scan: PERIOD=10us, GAP=4, all channels.
        wr(8'h02, 8'd10);
        wr(8'h03, 8'd0);
        wr(8'h04, 8'd4);
        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < 8; i++) begin
                push_start(8'(1 << i), (i == 0) ? -1 : 5);
            end
        end
        last_done    = -1;
        done_gap_exp = 10 * US;
        wr(8'h00, 8'h01);
        wait_done(3, 500);
        wr(8'h00, 8'h00);
        done_gap_exp = 0;
        wait_starts(10);
        rd("basic_cnt_lo", 8'h06, 8'd3);
        rd("basic_cnt_hi", 8'h07, 8'd0);
        rd("basic_status", 8'h05, 8'h1C);

        // Sparse channels, GAP=0, single shot with RUN=0.
        wr(8'h01, 8'h81);
        wr(8'h04, 8'd0);
        push_start(8'h01, -1);
        push_start(8'h80, 1);
        wr(8'h00, 8'h02);
        wait_done(4, 100);
        idle(200);
        check("shot_once", 32'(n_done), 32'd4);
        wait_starts(5);
        rd("shot_ctrl", 8'h00, 8'h00);
        rd("shot_cnt_lo", 8'h06, 8'd4);

        // Overrun: PERIOD=1, channel 2 stays busy while ticks arrive.
        wr(8'h02, 8'd1);
        wr(8'h01, 8'hFF);
        ad_busy = 8'h04;
        for (int i = 0; i < 8; i++) begin
            push_start(8'(1 << i), (i == 0) ? -1 : 1);
        end
        wr(8'h00, 8'h01);
        wait_starts(50);
        idle(3 * US);
        wr(8'h00, 8'h00);
        ad_busy = 8'h00;
        wait_done(5, 50);
        idle(50);
        check("ovr_one_scan", 32'(n_done), 32'd5);
        rd("ovr_status", 8'h05, 8'h1E);
        wr(8'h00, 8'h04);
        rd("ovr_cleared", 8'h05, 8'h1C);
        rd("ovr_ctrl", 8'h00, 8'h00);

        // Reset asserted while the FSM sits in GAP.
        wr(8'h04, 8'd4);
        push_start(8'h01, -1);
        wr(8'h00, 8'h02);
        wait_starts(50);
        rst_n = 1'b0;
        #1;
        check("mid_rst_start", 32'(ad_start), 32'h0);
        check("mid_rst_done", 32'(scan_done), 32'h0);
        idle(2);
        rst_n = 1'b1;
        rd("mid_rst_status", 8'h05, 8'h00);
        rd("mid_rst_ch_en", 8'h01, 8'hFF);
        idle(60);
        check("mid_rst_no_done", 32'(n_done), 32'd5);

        // Empty enable mask: scan_done without any start.
        wr(8'h01, 8'h00);
        wr(8'h00, 8'h02);
        wait_done(6, 20);
        rd("empty_cnt_lo", 8'h06, 8'd1);

        // Channel 0 stuck busy.
        wr(8'h01, 8'h01);
        ad_busy = 8'h01;
        push_start(8'h01, -1);
        wr(8'h00, 8'h02);
        wait_starts(50);
`ifdef SCAN_TIMEOUT_EN
        idle(255 * US + 60);
        check("tmo_no_done", 32'(n_done), 32'd6);
        rd("tmo_status", 8'h05, 8'h20);
        ad_busy = 8'h00;
        idle(20);
        check("tmo_still_no_done", 32'(n_done), 32'd6);
        rd("tmo_cnt_lo", 8'h06, 8'd1);
`else
        idle(300);
        rd("stuck_status", 8'h05, 8'h01);
        check("stuck_no_done", 32'(n_done), 32'd6);
        ad_busy = 8'h00;
        wait_done(7, 20);
        rd("stuck_cnt_lo", 8'h06, 8'd2);
`endif

        idle(5);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ad_scan_sched.md
Name: ad_scan_sched

Overview:
- Schedules sample conversions for the eight AD channel front-ends (ad_top instances).
- On a programmable period measured in pluse_us ticks, it pulses a start strobe to each enabled channel in turn, staggered by a configurable gap, then waits for all channel busy flags to clear.
- Configured and monitored as an fx bus slave, at dev_id 6'h02.

Parameters:
NCH, 8, number of channels scheduled (1..8); register bits above NCH-1 read 0
PERIOD_RST, 16'd1000, reset value of PERIOD register (us)
GAP_RST, 8'd4, reset value of GAP register (clk_sys cycles)

Ports:
clk_sys  in  1  system clock
rst_n  in  1  asynchronous active-low reset
pluse_us  in  1  one-clk_sys pulse every microsecond
dev_id  in  6  fx bus device id
fx_waddr  in  22  fx write address
fx_wr  in  1  fx write strobe
fx_data  in  8  fx write data
fx_rd  in  1  fx read strobe
fx_raddr  in  22  fx read address
fx_q  out  8  fx read data; 0 when not selected
ad_busy  in  NCH  per-channel conversion in progress
ad_start  out  NCH  per-channel one-cycle start pulse
scan_done  out  1  one-cycle pulse at end of each scan

Behaviour:
- Reset: all outputs 0; registers at reset values; FSM in IDLE; all counters 0.
- Write decode: selected when fx_wr=1 and fx_waddr[21:16]==dev_id. Register offset is fx_waddr[7:0]. Writes take effect on the next clock.
- Read decode: same decode on fx_raddr. fx_q is registered 1 clk after fx_rd, and holds 0 on any unselected or unmapped read.
- Registers:
  - 0x00 CTRL: [0] RUN (rw, reset 0); [1] SHOT (write 1 = request one scan; self-clears when that scan starts); [2] CLR (write 1 clears OVR/TMO; reads 0).
  - 0x01 CH_EN: rw, reset 8'hFF.
  - 0x02/0x03 PERIOD lo/hi: rw, 16 bit. Value 0 is treated as 1.
  - 0x04 GAP: rw.
  - 0x05 STATUS: ro. [0] BUSY (FSM not IDLE); [1] OVR sticky; [4:2] current channel index; [5] TMO sticky.
  - 0x06/0x07 SCAN_CNT lo/hi: ro, 16 bit, wraps 0xFFFF->0.
- Period counter:
  - Increments on pluse_us while RUN=1. Cleared while RUN=0.
  - On pluse_us with count==PERIOD-1: generates tick and reloads to 0.
- FSM states: IDLE, START, GAP, WAIT_DONE.
  - IDLE: on tick or pending SHOT, go to START at the first enabled channel; clear SHOT.
  - If CH_EN==0: no starts; pulse scan_done and increment SCAN_CNT next clk; return to IDLE.
  - START: assert ad_start[ch] for exactly 1 clk. The first start occurs 1 clk after the tick cycle. Then:
    - GAP>0: go to GAP.
    - GAP=0, more enabled channels remain: START on the next enabled channel, so starts are back-to-back.
    - No enabled channels remain: go to WAIT_DONE.
  - GAP: count GAP clocks, then go to START for the next enabled channel, or WAIT_DONE if none remain. Disabled channels are skipped with no gap cost.
  - WAIT_DONE: the first clock is a guard cycle. From then on, when (ad_busy & CH_EN-snapshot)==0, pulse scan_done, increment SCAN_CNT, and go to IDLE.
- CH_EN and GAP are snapshotted at scan start. Writes during a scan apply to the next scan.
- Tick while not IDLE: tick dropped and OVR set. Tick and CLR in the same clk: OVR ends set.
- RUN cleared mid-scan: the current scan completes; no new ticks.
- SHOT written mid-scan: held pending; serviced from IDLE.
- Async reset mid-scan: immediate return to reset state. Any ad_start in flight is deasserted.

Optional Feature:
SCAN_TIMEOUT_EN
- Defined: WAIT_DONE has a timeout of 255 pluse_us ticks. On expiry: set TMO, go to IDLE, no scan_done, SCAN_CNT unchanged.
- Undefined: WAIT_DONE waits indefinitely; STATUS[5] reads 0.

Test Plan:
- Basic periodic scan. Setup: PERIOD=10, GAP=4, CH_EN=FF, RUN=1, ad_busy tied 0. Required:
  - ad_start[0..7] pulses spaced 5 clks.
  - scan_done once per 10 us.
  - SCAN_CNT reads 3 after 3 periods.
- Sparse channels. Setup: CH_EN=8'h81, GAP=0. Required: ad_start[0] then ad_start[7] on consecutive clks; no other start bits.
- Overrun. Setup: PERIOD=1, ad_busy[2] held high 3 us. Required:
  - STATUS[1]=1.
  - Ticks during the scan are dropped (exactly one scan in flight).
  - Writing CTRL=0x04 clears STATUS[1] to 0.
- Single shot. Setup: RUN=0, write CTRL=0x02. Required: exactly one scan, one scan_done, SCAN_CNT=1, CTRL[1] reads 0.
- Reset mid-scan. Setup: assert rst_n=0 during GAP. Required: ad_start=0 and scan_done=0 immediately; STATUS=0 and CH_EN=FF after release.
- Timeout (SCAN_TIMEOUT_EN defined). Setup: ad_busy[0] stuck high. Required: after 255 us STATUS[5]=1, FSM IDLE, no scan_done.
